// File: rtl/lamp_sequencer.sv
// Lamp bank pattern generator: prescaled step tick drives CHASE/FILL/BLINK/ALLON patterns.
// Optional build macro LAMP_SEQ_BOUNCE_EN turns CHASE into a ping-pong sweep.
module lamp_sequencer #(
    parameter int NUM_LAMPS   = 11,
    parameter int DIV_WIDTH   = 16,
    parameter int STEP_DIV    = 50000,
    parameter int BLINK_COUNT = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic                 stop,
    output logic [NUM_LAMPS-1:0] lamps,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [1:0] MODE_CHASE = 2'b00;
    localparam logic [1:0] MODE_FILL  = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;

    localparam logic [NUM_LAMPS-1:0] ALL_ON    = {NUM_LAMPS{1'b1}};
    localparam logic [NUM_LAMPS-1:0] FIRST_BIT = NUM_LAMPS'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_LAST  = DIV_WIDTH'(STEP_DIV - 1);
    localparam int                   BW        = $clog2(2 * BLINK_COUNT);
    localparam logic [BW-1:0]        BLINK_LAST = BW'(2 * BLINK_COUNT - 1);

    state_t                 state_q;
    logic [1:0]             mode_q;
    logic [DIV_WIDTH-1:0]   presc_q;
    logic [NUM_LAMPS-1:0]   lamps_q;
    logic                   busy_q;
    logic                   done_q;
    logic [BW-1:0]          blink_q;

    logic                   tick;
    logic                   finish_d;
    logic [NUM_LAMPS-1:0]   lamps_d;
    logic [NUM_LAMPS-1:0]   first_lamps;
    logic [BW-1:0]          blink_d;
`ifdef LAMP_SEQ_BOUNCE_EN
    logic                   dir_q;
    logic                   dir_d;
`endif

    assign tick        = (presc_q == DIV_LAST);
    assign first_lamps = (mode == MODE_CHASE || mode == MODE_FILL) ? FIRST_BIT : ALL_ON;

    // Next pattern value and whether the current tick ends the pattern.
    always_comb begin
        lamps_d  = lamps_q;
        finish_d = 1'b0;
        blink_d  = blink_q;
`ifdef LAMP_SEQ_BOUNCE_EN
        dir_d    = dir_q;
`endif
        case (mode_q)
            MODE_CHASE: begin
`ifdef LAMP_SEQ_BOUNCE_EN
                if (!dir_q) begin
                    if (lamps_q[NUM_LAMPS-1]) begin
                        dir_d   = 1'b1;
                        lamps_d = lamps_q >> 1;
                    end else begin
                        lamps_d = lamps_q << 1;
                    end
                end else if (lamps_q[0]) begin
                    finish_d = 1'b1;
                end else begin
                    lamps_d = lamps_q >> 1;
                end
`else
                if (lamps_q[NUM_LAMPS-1]) finish_d = 1'b1;
                else                      lamps_d  = lamps_q << 1;
`endif
            end
            MODE_FILL: begin
                if (lamps_q == ALL_ON) finish_d = 1'b1;
                else                   lamps_d  = (lamps_q << 1) | FIRST_BIT;
            end
            MODE_BLINK: begin
                if (blink_q == BLINK_LAST) begin
                    finish_d = 1'b1;
                end else begin
                    blink_d = blink_q + 1'b1;
                    lamps_d = ~lamps_q;
                end
            end
            default: finish_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'b00;
            presc_q <= '0;
            lamps_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            blink_q <= '0;
`ifdef LAMP_SEQ_BOUNCE_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_q <= ST_RUN;
                        mode_q  <= mode;
                        presc_q <= '0;
                        lamps_q <= first_lamps;
                        busy_q  <= 1'b1;
                        blink_q <= '0;
`ifdef LAMP_SEQ_BOUNCE_EN
                        dir_q   <= 1'b0;
`endif
                    end
                end
                default: begin
                    // Abort takes priority over a finishing tick in the same cycle.
                    if (stop) begin
                        state_q <= ST_IDLE;
                        presc_q <= '0;
                        lamps_q <= '0;
                        busy_q  <= 1'b0;
                        blink_q <= '0;
`ifdef LAMP_SEQ_BOUNCE_EN
                        dir_q   <= 1'b0;
`endif
                    end else if (tick) begin
                        presc_q <= '0;
                        if (finish_d) begin
                            state_q <= ST_IDLE;
                            lamps_q <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            lamps_q <= lamps_d;
                            blink_q <= blink_d;
`ifdef LAMP_SEQ_BOUNCE_EN
                            dir_q   <= dir_d;
`endif
                        end
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign lamps = lamps_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
